// File: rtl/uart_bus_bridge_if.sv
// UART byte-stream and native memory bus signals between the bridge (master) and its environment (slave).
interface uart_bus_bridge_if;
  logic        rx_full;
  logic [7:0]  rx_dout;
  logic        rx_re;
  logic        tx_empty;
  logic        tx_we;
  logic [7:0]  tx_din;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    input  rx_full, rx_dout, tx_empty, mem_ready, mem_rdata,
    output rx_re, tx_we, tx_din, mem_valid, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    output rx_full, rx_dout, tx_empty, mem_ready, mem_rdata,
    input  rx_re, tx_we, tx_din, mem_valid, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/uart_bus_bridge.sv
// UART-driven debug bus initiator: W/R/G/H byte frames become bus accesses, replies and cpu_hold changes.
// Optional inter-byte timeout in ADDR/DATA is enabled with `UART_BUS_BRIDGE_TIMEOUT_EN.
module uart_bus_bridge #(
  parameter bit          HOLD_AT_RESET  = 1'b1,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15,
  parameter int unsigned TIMEOUT_CYCLES = 32'd2500000
) (
  input  logic               clk,
  input  logic               rst,
  uart_bus_bridge_if.master  bus,
  output logic               cpu_hold,
  output logic               busy
);

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_G = 8'h47;
  localparam logic [7:0] CMD_H = 8'h48;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_SEND} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  reply_q, reply_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        hold_q, hold_d;
  logic        rx_guard_q, rx_guard_d;
  logic        tx_guard_q, tx_guard_d;
  logic        rx_pop, tx_push;
  logic [7:0]  tx_byte;
`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;
`else
  wire         unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 2'd0;
      cmd_q      <= 8'h00;
      reply_q    <= 8'h00;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      hold_q     <= HOLD_AT_RESET;
      rx_guard_q <= 1'b0;
      tx_guard_q <= 1'b0;
`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
      tmo_q      <= 32'h0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      reply_q    <= reply_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      hold_q     <= hold_d;
      rx_guard_q <= rx_guard_d;
      tx_guard_q <= tx_guard_d;
`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    reply_d    = reply_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    hold_d     = hold_q;
    tx_push    = 1'b0;
    tx_byte    = 8'h00;
    // Pops are combinational so rx_dout is captured on the same edge the UART sees rx_re.
    rx_pop     = !rst && !rx_guard_q && bus.rx_full &&
                 (state_q == S_IDLE || state_q == S_ADDR || state_q == S_DATA);
    rx_guard_d = rx_pop;
    tx_guard_d = 1'b0;
`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
    tmo_d      = 32'h0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (rx_pop) begin
          cmd_d = bus.rx_dout;
          cnt_d = 2'd0;
          unique case (bus.rx_dout)
            CMD_W, CMD_R: begin
              reply_d = ACK_BYTE;
              state_d = S_ADDR;
            end
            CMD_G: begin
              hold_d  = 1'b0;
              reply_d = ACK_BYTE;
              state_d = S_SEND;
            end
            CMD_H: begin
              hold_d  = 1'b1;
              reply_d = ACK_BYTE;
              state_d = S_SEND;
            end
            default: begin
              reply_d = NAK_BYTE;
              state_d = S_SEND;
            end
          endcase
        end
      end
      S_ADDR: begin
        if (rx_pop) begin
          addr_d[{cnt_q, 3'b000} +: 8] = bus.rx_dout;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = (cmd_q == CMD_W) ? S_DATA : S_BUS;
        end
      end
      S_DATA: begin
        if (rx_pop) begin
          wdata_d[{cnt_q, 3'b000} +: 8] = bus.rx_dout;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_BUS;
        end
      end
      S_BUS: begin
        if (bus.mem_ready) begin
          if (cmd_q == CMD_R) rdata_d = bus.mem_rdata;
          cnt_d   = 2'd0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        tx_byte    = (cmd_q == CMD_R) ? rdata_q[{cnt_q, 3'b000} +: 8] : reply_q;
        tx_push    = !rst && !tx_guard_q && bus.tx_empty;
        tx_guard_d = tx_push;
        if (tx_push) begin
          if (cmd_q == CMD_R && cnt_q != 2'd3) begin
            cnt_d = cnt_q + 2'd1;
          end else begin
            cnt_d   = 2'd0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
    // A received byte always wins over an expiring gap counter in the same cycle.
    if (state_q == S_ADDR || state_q == S_DATA) begin
      if (rx_pop) begin
        tmo_d = 32'h0;
      end else if (tmo_q == TIMEOUT_CYCLES - 1) begin
        state_d = S_IDLE;
        cnt_d   = 2'd0;
      end else begin
        tmo_d = tmo_q + 32'd1;
      end
    end
`endif
  end

  assign bus.rx_re     = rx_pop;
  assign bus.tx_we     = tx_push;
  assign bus.tx_din    = tx_byte;
  assign bus.mem_valid = (state_q == S_BUS);
  assign bus.mem_addr  = {addr_q[31:2], 2'b00};
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = (state_q == S_BUS && cmd_q == CMD_W) ? 4'hF : 4'h0;
  assign cpu_hold      = hold_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Self-checking bench: UART feeder, TX and bus monitors with scoreboards, table-driven frames plus reset/timeout corners.
module tb_uart_bus_bridge;
  logic clk;
  logic rst;
  logic cpu_hold;
  logic busy;

  uart_bus_bridge_if bus();

  uart_bus_bridge #(
    .HOLD_AT_RESET (1'b1),
    .ACK_BYTE      (8'h06),
    .NAK_BYTE      (8'h15),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .cpu_hold(cpu_hold),
    .busy    (busy)
  );

  typedef struct {
    logic [71:0] bytes;     // byte i at [8i+7:8i]
    int          nbytes;
    logic [31:0] rdata;
    int          lat;       // cycles between valid and ready
    bit          has_bus;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk_wdata;
    logic [3:0]  strb;
    int          ntx;
    logic [31:0] tx;        // reply bytes, first at [7:0]
    int          stall_at;  // after this many pushes hold tx_empty low 50 cycles (0 = never)
    logic        hold;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk_wdata;
    logic [3:0]  strb;
    int          width;
  } bus_t;

  int          compared   = 0;
  int          mismatched = 0;
  logic [7:0]  rx_fifo[$];
  logic [7:0]  tx_exp[$];
  bus_t        bus_exp[$];
  int          cur_lat    = 0;
  bit          bus_abort  = 0;
  int          rx_pops    = 0;
  int          tx_pushes  = 0;
  int          stall_at   = -1;
  vec_t        vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: got event expected none", name);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // UART receive side: presents queued bytes, pops on sampled rx_re
  initial begin
    logic pop;
    logic prev;
    prev = 1'b0;
    bus.rx_full = 1'b0;
    bus.rx_dout = 8'h00;
    forever begin
      @(negedge clk);
      pop = bus.rx_re;
      if (pop) begin
        rx_pops++;
        if (prev) fail_now("rx_back_to_back");
        if (!bus.rx_full) fail_now("rx_pop_when_empty");
      end
      prev = pop;
      @(posedge clk);
      #1;
      if (pop && rx_fifo.size() > 0) void'(rx_fifo.pop_front());
      bus.rx_full = (rx_fifo.size() > 0);
      bus.rx_dout = (rx_fifo.size() > 0) ? rx_fifo[0] : 8'h00;
    end
  end

  // UART transmit side: checks pushed bytes against the scoreboard, optionally stalls
  initial begin
    int   stall_left;
    logic prev_we;
    stall_left   = 0;
    prev_we      = 1'b0;
    bus.tx_empty = 1'b1;
    forever begin
      @(negedge clk);
      if (!bus.tx_empty) chk("tx_no_push_while_full", {31'd0, bus.tx_we}, 32'd0);
      if (bus.tx_we) begin
        tx_pushes++;
        if (prev_we) fail_now("tx_back_to_back");
        if (tx_exp.size() == 0) fail_now("tx_unexpected");
        else chk("tx_byte", {24'd0, bus.tx_din}, {24'd0, tx_exp.pop_front()});
        if (tx_pushes == stall_at) stall_left = 50;
      end
      prev_we = bus.tx_we;
      @(posedge clk);
      #1;
      bus.tx_empty = (stall_left == 0);
      if (stall_left > 0) stall_left--;
    end
  end

  // Memory slave: ready after cur_lat cycles, checks each transaction on completion
  initial begin
    int          vcnt;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic [3:0]  a_strb;
    bit          stable;
    bus_t        e;
    vcnt          = 0;
    stable        = 1'b1;
    a_addr        = '0;
    a_wdata       = '0;
    a_strb        = '0;
    bus.mem_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.mem_valid) begin
        vcnt++;
        if (vcnt == 1) begin
          a_addr  = bus.mem_addr;
          a_wdata = bus.mem_wdata;
          a_strb  = bus.mem_wstrb;
          stable  = 1'b1;
        end else if (bus.mem_addr !== a_addr || bus.mem_wdata !== a_wdata || bus.mem_wstrb !== a_strb) begin
          stable = 1'b0;
        end
        bus.mem_ready = (vcnt > cur_lat);
      end else begin
        bus.mem_ready = 1'b0;
        if (vcnt > 0) begin
          if (!bus_abort) begin
            if (bus_exp.size() == 0) begin
              fail_now("bus_unexpected");
            end else begin
              e = bus_exp.pop_front();
              chk("bus_addr", a_addr, e.addr);
              chk("bus_wstrb", {28'd0, a_strb}, {28'd0, e.strb});
              if (e.chk_wdata) chk("bus_wdata", a_wdata, e.wdata);
              chk("bus_valid_width", vcnt, e.width);
              chk("bus_stable", {31'd0, stable}, 32'd1);
            end
          end
          vcnt = 0;
        end
      end
    end
  end

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (n < 3000 && !(rx_fifo.size() == 0 && tx_exp.size() == 0 && bus_exp.size() == 0 && !busy)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) fail_now({name, "_timeout"});
    repeat (2) @(negedge clk);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    logic [71:0] b;
    logic [31:0] t;
    bus_t        e;
    int          rx0;
    int          tx0;
    b   = v.bytes;
    t   = v.tx;
    rx0 = rx_pops;
    tx0 = tx_pushes;
    bus.mem_rdata = v.rdata;
    cur_lat       = v.lat;
    stall_at      = (v.stall_at > 0) ? tx_pushes + v.stall_at : -1;
    if (v.has_bus) begin
      e.addr      = v.addr;
      e.wdata     = v.wdata;
      e.chk_wdata = v.chk_wdata;
      e.strb      = v.strb;
      e.width     = v.lat + 1;
      bus_exp.push_back(e);
    end
    for (int i = 0; i < v.ntx; i++) tx_exp.push_back(t[8*i +: 8]);
    for (int i = 0; i < v.nbytes; i++) rx_fifo.push_back(b[8*i +: 8]);
    wait_done(name);
    chk({name, "_rx_pops"}, rx_pops - rx0, v.nbytes);
    chk({name, "_tx_pushes"}, tx_pushes - tx0, v.ntx);
    chk({name, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, v.hold});
  endtask

  initial begin
    vec_t g;
    int   n;
    vecs[0] = '{bytes:72'hDEADBEEF_00001000_57, nbytes:9, rdata:32'h0, lat:2, has_bus:1'b1,
                addr:32'h0000_1000, wdata:32'hDEAD_BEEF, chk_wdata:1'b1, strb:4'hF,
                ntx:1, tx:32'h06, stall_at:0, hold:1'b1};
    vecs[1] = '{bytes:72'h00003004_52, nbytes:5, rdata:32'h1234_5678, lat:0, has_bus:1'b1,
                addr:32'h0000_3004, wdata:32'h0, chk_wdata:1'b0, strb:4'h0,
                ntx:4, tx:32'h1234_5678, stall_at:1, hold:1'b1};
    vecs[2] = '{bytes:72'h47, nbytes:1, rdata:32'h0, lat:0, has_bus:1'b0,
                addr:32'h0, wdata:32'h0, chk_wdata:1'b0, strb:4'h0,
                ntx:1, tx:32'h06, stall_at:0, hold:1'b0};
    vecs[3] = '{bytes:72'h48, nbytes:1, rdata:32'h0, lat:0, has_bus:1'b0,
                addr:32'h0, wdata:32'h0, chk_wdata:1'b0, strb:4'h0,
                ntx:1, tx:32'h06, stall_at:0, hold:1'b1};
    vecs[4] = '{bytes:72'h5A, nbytes:1, rdata:32'h0, lat:0, has_bus:1'b0,
                addr:32'h0, wdata:32'h0, chk_wdata:1'b0, strb:4'h0,
                ntx:1, tx:32'h15, stall_at:0, hold:1'b1};
    vecs[5] = '{bytes:72'h11223344_00002003_57, nbytes:9, rdata:32'h0, lat:1, has_bus:1'b1,
                addr:32'h0000_2000, wdata:32'h1122_3344, chk_wdata:1'b1, strb:4'hF,
                ntx:1, tx:32'h06, stall_at:0, hold:1'b1};
    vecs[6] = '{bytes:72'h80000008_52, nbytes:5, rdata:32'hA5A5_5A5A, lat:3, has_bus:1'b1,
                addr:32'h8000_0008, wdata:32'h0, chk_wdata:1'b0, strb:4'h0,
                ntx:4, tx:32'hA5A5_5A5A, stall_at:0, hold:1'b1};
    g = vecs[2];

    bus.mem_rdata = 32'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
    chk("rst_rx_re", {31'd0, bus.rx_re}, 32'd0);
    chk("rst_tx_we", {31'd0, bus.tx_we}, 32'd0);
    chk("rst_tx_din", {24'd0, bus.tx_din}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_mem_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
    // Partial read frame then silence: bridge must give up without replying
    rx_fifo.push_back(8'h52);
    rx_fifo.push_back(8'h00);
    n = 0;
    while (!busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_entered_busy", {31'd0, busy}, 32'd1);
    n = 0;
    while (busy && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_busy_cycles_in_range", {31'd0, (n >= 100 && n <= 104)}, 32'd1);
    repeat (5) @(negedge clk);
    chk("tmo_no_reply", tx_exp.size(), 0);
    run_vec("tmo_then_go", g);
`endif

    // Reset in the middle of an unfinished bus write
    run_vec("pre_rst_go", g);
    bus_abort = 1'b1;
    cur_lat   = 100000;
    for (int i = 0; i < 9; i++) rx_fifo.push_back((i == 0) ? 8'h57 : 8'hA0 + 8'(i));
    n = 0;
    while (!bus.mem_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_valid_seen", {31'd0, bus.mem_valid}, 32'd1);
    repeat (2) @(negedge clk);
    chk("rst_mid_ready_low", {31'd0, bus.mem_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    bus_abort = 1'b0;
    cur_lat   = 0;
    chk("rst_mid_no_reply", tx_exp.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
